// File: rtl/arbitro_rr_mux4x1.sv
// Round-robin arbiter/sequencer for the 4x1 memory mux. Serves each requesting
// lane for a burst of at most BURST_MAX transfers, then rotates to the next requester.
module arbitro_rr_mux4x1 #(
  parameter int BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] selector4x1,
  output logic       valid_input,
  output logic       busy
);

  localparam int CW = $clog2(BURST_MAX) + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cur_q, cur_d;
  logic [1:0]      last_q, last_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            rel;

  // First requesting lane at or after s (wrapping); scanning downward lets the
  // lowest offset win. Returns s when nothing requests; callers guard on req != 0.
  function automatic logic [1:0] rr_search(input logic [3:0] r, input logic [1:0] s);
    logic [1:0] idx;
    rr_search = s;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (r[idx]) rr_search = idx;
    end
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cur_q   <= 2'd0;
      last_q  <= 2'd3;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign rel = !req[cur_q] || (valid_input && (bcnt_q == CW'(BURST_MAX - 1)));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          state_d = GRANT;
          cur_d   = rr_search(req, last_q + 2'd1);
          bcnt_d  = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          bcnt_d = bcnt_q + CW'(valid_input);
        end else begin
          last_d = cur_q;
          bcnt_d = '0;
          // The current lane is examined last, so a sole requester keeps
          // streaming with no bubble between bursts.
          if (req == 4'b0000) state_d = IDLE;
          else                cur_d   = rr_search(req, cur_q + 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == GRANT);
    grant       = busy ? (4'b0001 << cur_q) : 4'b0000;
    selector4x1 = cur_q;
    valid_input = busy && req[cur_q];
  end

endmodule
